// File: rtl/weight_writeback.sv
// weight_writeback: buffers updated-weight beats from the SGD stage in a small
// FIFO and drains them to the weight memory as chunk-addressed write requests.
// Each entry carries the chunk index it was tagged with on arrival, so a dropped
// beat never shifts the addresses of the beats that follow it.
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both 1. Input side: push = in_valid & in_ready. Memory side:
// pop = mem_wr_en & mem_ready. While mem_wr_en is 1 and mem_ready is 0 the
// request (mem_addr/mem_wdata) is held unchanged. An in_valid beat seen with
// in_ready=0 is discarded and recorded in the sticky overflow flag.
module weight_writeback #(
  parameter int bitwidth    = 16,
  parameter int size        = 4,
  parameter int NumCycle    = 8,
  parameter int logNumCycle = 3,
  parameter int depth       = 4,
  parameter int logDepth    = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [bitwidth*size-1:0]    data_in,
  output logic                        in_ready,
  input  logic                        mem_ready,
  output logic                        mem_wr_en,
  output logic [logNumCycle-1:0]      mem_addr,
  output logic [bitwidth*size-1:0]    mem_wdata,
  output logic                        busy,
  output logic                        sample_done,
  output logic                        overflow
);

  localparam int DW = bitwidth * size;
  localparam int EW = logNumCycle + DW;

  localparam logic [logDepth:0]      DEPTH_C    = (logDepth + 1)'(depth);
  localparam logic [logDepth:0]      CNT_ONE    = (logDepth + 1)'(1);
  localparam logic [logDepth-1:0]    PTR_ONE    = logDepth'(1);
  localparam logic [logNumCycle-1:0] LAST_CHUNK = logNumCycle'(NumCycle - 1);
  localparam logic [logNumCycle-1:0] CHUNK_ONE  = logNumCycle'(1);

  // Entry storage: {chunk index, data}
  logic [EW-1:0] mem_q [depth];

  logic [logDepth-1:0]    wr_ptr_q, wr_ptr_d;
  logic [logDepth-1:0]    rd_ptr_q, rd_ptr_d;
  logic [logDepth:0]      count_q, count_d;
  logic [logNumCycle-1:0] wr_chunk_q, wr_chunk_d;
  logic                   overflow_q, overflow_d;
  logic                   sample_done_q, sample_done_d;

  logic                   not_empty;
  logic                   push, pop;
  logic [EW-1:0]          head;
  logic [logNumCycle-1:0] head_chunk;

  assign not_empty  = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_chunk = head[EW-1 -: logNumCycle];

  // Handshake decode and next-state computation for pointers, count and flags
  always_comb begin
    pop           = not_empty & mem_ready;
    in_ready      = (count_q < DEPTH_C) | pop;
    push          = in_valid & in_ready;

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    wr_chunk_d    = wr_chunk_q;
    overflow_d    = overflow_q;
    sample_done_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Chunk position follows the producer, not the FIFO: dropped beats still advance it
    if (in_valid) begin
      wr_chunk_d = (wr_chunk_q == LAST_CHUNK) ? '0 : wr_chunk_q + CHUNK_ONE;
    end

    if (in_valid & ~in_ready) overflow_d = 1'b1;

    sample_done_d = pop & (head_chunk == LAST_CHUNK);
  end

  // Control state register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wr_chunk_q    <= '0;
      overflow_q    <= 1'b0;
      sample_done_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      wr_chunk_q    <= wr_chunk_d;
      overflow_q    <= overflow_d;
      sample_done_q <= sample_done_d;
    end
  end

  // Entry storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_chunk_q, data_in};
  end

  // Memory request driven from the FIFO head, forced to zero when empty
  always_comb begin
    mem_wr_en = not_empty;
    busy      = not_empty;
    mem_addr  = '0;
    mem_wdata = '0;
    if (not_empty) begin
      mem_addr  = head_chunk;
      mem_wdata = head[DW-1:0];
    end
  end

  assign sample_done = sample_done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_weight_writeback.sv
// Testbench for weight_writeback: directed scenarios plus a random phase,
// checked against a queue-based reference model of the write-back buffer.
module tb_weight_writeback;

  localparam int BW    = 16;
  localparam int SZ    = 4;
  localparam int NC    = 8;
  localparam int LNC   = 3;
  localparam int DEP   = 4;
  localparam int LDEP  = 2;
  localparam int DW    = BW * SZ;

  // ---------------- clock / reset / DUT ----------------
  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   data_in = '0;
  logic            in_ready;
  logic            mem_ready = 1'b0;
  logic            mem_wr_en;
  logic [LNC-1:0]  mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            busy;
  logic            sample_done;
  logic            overflow;

  always #5 clk = ~clk;

  weight_writeback #(
    .bitwidth(BW), .size(SZ), .NumCycle(NC), .logNumCycle(LNC),
    .depth(DEP), .logDepth(LDEP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .data_in(data_in),
    .in_ready(in_ready), .mem_ready(mem_ready), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
    .sample_done(sample_done), .overflow(overflow)
  );

  // ---------------- reference model / scoreboard ----------------
  // Each expected entry is {chunk, data}; the head is the pending write.
  logic [LNC+DW-1:0] exp_q[$];
  int                m_chunk;
  bit                m_overflow;
  bit                m_sd;
  int                sd_pulses;
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_chunk    = 0;
    m_overflow = 0;
    m_sd       = 0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- driver ----------------
  // One clock cycle: drive inputs after the falling edge, check outputs while
  // they are stable, then advance the model by what the next rising edge does.
  task automatic step(input bit v, input logic [DW-1:0] d, input bit mr);
    bit                exp_ready, do_pop, do_push, nonempty;
    logic [LNC-1:0]    h_chunk;
    logic [DW-1:0]     h_data;
    @(negedge clk);
    in_valid  = v;
    data_in   = d;
    mem_ready = mr;
    #1;
    nonempty  = (exp_q.size() != 0);
    h_chunk   = nonempty ? exp_q[0][LNC+DW-1:DW] : '0;
    h_data    = nonempty ? exp_q[0][DW-1:0]      : '0;
    do_pop    = nonempty && mr;
    exp_ready = (exp_q.size() < DEP) || do_pop;
    do_push   = v && exp_ready;

    chk("in_ready",    64'(in_ready),    64'(exp_ready));
    chk("mem_wr_en",   64'(mem_wr_en),   64'(nonempty));
    chk("busy",        64'(busy),        64'(nonempty));
    chk("mem_addr",    64'(mem_addr),    64'(h_chunk));
    chk("mem_wdata",   64'(mem_wdata),   64'(h_data));
    chk("overflow",    64'(overflow),    64'(m_overflow));
    chk("sample_done", 64'(sample_done), 64'(m_sd));
    if (sample_done) sd_pulses++;

    m_sd = do_pop && (h_chunk == LNC'(NC - 1));
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) exp_q.push_back({LNC'(m_chunk), d});
    if (v && !exp_ready) m_overflow = 1;
    if (v) m_chunk = (m_chunk + 1) % NC;
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mem_wr_en",   64'(mem_wr_en),   64'd0);
    chk("rst_mem_addr",    64'(mem_addr),    64'd0);
    chk("rst_mem_wdata",   64'(mem_wdata),   64'd0);
    chk("rst_busy",        64'(busy),        64'd0);
    chk("rst_overflow",    64'(overflow),    64'd0);
    chk("rst_sample_done", 64'(sample_done), 64'd0);
    chk("rst_in_ready",    64'(in_ready),    64'd1);
    model_clear();
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic drain(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, '0, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [DW-1:0] d;
    int            pulses_before;
    model_clear();
    sd_pulses = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 1: reset with three entries buffered
    for (int k = 0; k < 3; k++) step(1'b1, rand_data(), 1'b0);
    chk("t1_busy_before_rst", 64'(busy), 64'd1);
    in_valid = 1'b1;
    do_reset();

    // 2: eight beats, lane0 = k, memory always ready
    pulses_before = sd_pulses;
    for (int k = 0; k < 8; k++) begin
      d = rand_data();
      d[BW-1:0] = BW'(k);
      step(1'b1, d, 1'b1);
      if (k > 0) chk("t2_lane0_eq_addr", 64'(mem_wdata[BW-1:0]), 64'(mem_addr));
    end
    drain(3);
    chk("t2_sample_done_pulses", 64'(sd_pulses - pulses_before), 64'd1);

    // 3: fill with memory stalled, fifth beat dropped, addresses skip to 5
    do_reset();
    for (int k = 0; k < 5; k++) step(1'b1, rand_data(), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t3_overflow_direct", 64'(overflow), 64'd1);
    drain(4);
    step(1'b1, rand_data(), 1'b0);
    step(1'b0, '0, 1'b0);
    chk("t3_addr_after_drop", 64'(mem_addr), 64'd5);
    drain(2);

    // 4: full FIFO with simultaneous push and pop
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, rand_data(), 1'b0);
    step(1'b1, rand_data(), 1'b1);
    step(1'b0, '0, 1'b0);
    chk("t4_still_full", 64'(in_ready), 64'd0);
    chk("t4_no_overflow", 64'(overflow), 64'd0);
    drain(5);

    // 5: memory ready toggles every cycle, one beat every two cycles
    do_reset();
    pulses_before = sd_pulses;
    for (int c = 0; c < 32; c++) step(c % 2 == 0, rand_data(), c % 2 == 1);
    drain(4);
    chk("t5_sample_done_pulses", 64'(sd_pulses - pulses_before), 64'd2);

    // 6: twenty continuous beats, pointers wrap several times
    do_reset();
    for (int k = 0; k < 20; k++) step(1'b1, rand_data(), 1'b1);
    drain(3);

    // Random phase: mixed traffic, backpressure and occasional drops
    do_reset();
    for (int c = 0; c < 300; c++) begin
      step($urandom_range(0, 3) != 0, rand_data(), $urandom_range(0, 2) != 0);
    end
    drain(6);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
